fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter DEPTH, default 4: prefetch FIFO entries (power of two, >=2).
REQ-002 Parameter RESET_VECTOR, default 16'h0000: fetch address after reset.
REQ-003 Parameter HALT_OPCODE, default 8'hFF: byte value that stops fetching.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 fetch_en  input  1  permits fetching from program ROM.
REQ-007 rom_addr  output  16  program ROM address; ROM returns data combinationally.
REQ-008 rom_data  input  8  program ROM byte at rom_addr, valid same cycle.
REQ-009 redirect  input  1  single-cycle jump/branch request.
REQ-010 redirect_addr  input  16  new fetch address, sampled when redirect=1.
REQ-011 instr_valid  output  1  FIFO head holds a byte.
REQ-012 instr_ready  input  1  consumer accepts FIFO head.
REQ-013 instr_byte  output  8  byte at FIFO head.
REQ-014 instr_addr  output  16  ROM address from which instr_byte was fetched.
REQ-015 halted  output  1  high while FSM is in HALTED.
REQ-016 level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-017 rom_addr SHALL equal the internal fetch_pc register combinationally.
REQ-018 FSM states SHALL be IDLE, RUN, HALTED; halted=1 only in HALTED.
REQ-019 IDLE->RUN when fetch_en=1; RUN->IDLE when fetch_en=0; HALTED left only via redirect.
REQ-020 Push SHALL occur in a cycle when state=RUN, fetch_en=1, redirect=0, and (level<DEPTH or a pop occurs this cycle).
REQ-021 Push SHALL write {rom_data, fetch_pc} to FIFO tail and increment fetch_pc modulo 2^16 (16'hFFFF -> 16'h0000).
REQ-022 Push of a byte equal to HALT_OPCODE SHALL store that byte and move FSM RUN->HALTED at the same edge; fetch_pc still increments.
REQ-023 Pop SHALL occur when instr_valid=1 and instr_ready=1 and redirect=0; head advances at that edge.
REQ-024 instr_valid SHALL equal (level!=0); instr_byte/instr_addr SHALL be the head entry (don't-care when level=0).
REQ-025 Latency: byte fetched at edge N SHALL be visible on instr_valid/instr_byte in the cycle after edge N if FIFO was empty.
REQ-026 Simultaneous push and pop SHALL leave level unchanged, including at level=DEPTH.
REQ-027 At level=DEPTH without pop: no push, fetch_pc held, rom_addr stable.
REQ-028 redirect=1 SHALL, at the edge, flush FIFO (level=0), load fetch_pc<=redirect_addr, suppress push and pop, and set state to RUN if fetch_en=1 else IDLE, from any state.
REQ-029 In the cycle after redirect, rom_addr SHALL equal redirect_addr; first new byte appears one cycle later.
REQ-030 Pointers SHALL wrap modulo DEPTH; level SHALL never exceed DEPTH nor underflow.

Reset
REQ-031 rst_n=0 SHALL immediately, independent of clk: fetch_pc=RESET_VECTOR, level=0, instr_valid=0, state=IDLE, halted=0.
REQ-032 Reset mid-operation SHALL discard FIFO contents; after release, behaviour is identical to power-on.
REQ-033 FIFO data storage need not be reset; instr_byte/instr_addr are don't-care while instr_valid=0.

Verification
REQ-034 Reset release, fetch_en=1, instr_ready=1, ROM[0..3]=11,22,33,44 -> instr_byte 11,22,33,44 on consecutive cycles, instr_addr 0..3, first valid one cycle after first fetch edge.
REQ-035 instr_ready=0, fetch_en=1 -> level climbs to DEPTH(4), rom_addr holds 16'h0004; raise instr_ready -> level stays 4 with push+pop each cycle.
REQ-036 redirect=1 with redirect_addr=16'hFFFE while level=3 -> next cycle level=0, rom_addr=16'hFFFE; bytes then arrive from FFFE, FFFF, 0000 (wrap).
REQ-037 ROM[5]=FF -> after push of addr 5, halted=1, rom_addr=0006, no further pushes; FIFO drains to level=0; redirect to 16'h0010 -> halted=0, fetch resumes at 0010.
REQ-038 Drive rst_n=0 mid-stream with level=2, no clock edge -> instr_valid=0, rom_addr=RESET_VECTOR immediately.
REQ-039 fetch_en=0 in RUN with level=2 -> IDLE, no pushes, consumer still drains both bytes.

Source files
------------

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction byte prefetcher. A three-state FSM (IDLE / RUN / HALTED)
// streams bytes from a combinational program ROM into a small prefetch FIFO.
// Each FIFO entry holds the byte together with the ROM address it came from.
// A single-cycle redirect flushes the FIFO and restarts fetching at a new
// address. Fetching stops after a HALT_OPCODE byte has been queued, and
// only a redirect resumes it.
//
// Parameters
//   DEPTH         prefetch FIFO entries (power of two, >= 2)
//   RESET_VECTOR  fetch address after reset
//   HALT_OPCODE   byte value that stops fetching
//
// Ports
//   clk            in   sole clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   fetch_en       in   permits fetching from the ROM
//   rom_addr       out  ROM address (always the current fetch pc)
//   rom_data       in   ROM byte at rom_addr, valid in the same cycle
//   redirect       in   one-cycle jump request
//   redirect_addr  in   jump target, sampled while redirect is high
//   instr_valid    out  FIFO head holds a byte
//   instr_ready    in   consumer accepts the FIFO head
//   instr_byte     out  byte at the FIFO head
//   instr_addr     out  ROM address of instr_byte
//   halted         out  FSM is in HALTED
//   level          out  FIFO occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter int unsigned DEPTH        = 4,
    parameter logic [15:0] RESET_VECTOR = 16'h0000,
    parameter logic [7:0]  HALT_OPCODE  = 8'hFF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     fetch_en,
    output logic [15:0]              rom_addr,
    input  logic [7:0]               rom_data,
    input  logic                     redirect,
    input  logic [15:0]              redirect_addr,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [7:0]               instr_byte,
    output logic [15:0]              instr_addr,
    output logic                     halted,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [LW-1:0] LVL_ONE  = LW'(1);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [15:0]    fetch_pc_q, fetch_pc_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]  level_q, level_d;

    logic           push;
    logic           pop;

    // FIFO storage. Not reset: entries are only observable once level
    // shows them as valid, and every valid entry has been written.
    logic [7:0]     entry_byte_q [DEPTH];
    logic [15:0]    entry_addr_q [DEPTH];

    // -----------------------------------------------------------------------
    // Handshake decode
    // -----------------------------------------------------------------------
    // A redirect overrides both sides of the FIFO in its cycle.
    assign pop  = (level_q != '0) && instr_ready && !redirect;

    // Pushing into a full FIFO is allowed when the head leaves in the same
    // cycle, so a steady stream keeps the FIFO full with no bubbles.
    assign push = (state_q == ST_RUN) && fetch_en && !redirect &&
                  ((level_q != LVL_FULL) || pop);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;

        if (redirect) begin
            // Flush: pointers return to a common origin so the next push
            // lands at the new head.
            state_d    = fetch_en ? ST_RUN : ST_IDLE;
            fetch_pc_d = redirect_addr;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (fetch_en) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!fetch_en) begin
                        state_d = ST_IDLE;
                    end else if (push && (rom_data == HALT_OPCODE)) begin
                        // The halt byte itself is still queued for the
                        // consumer; only further fetching stops.
                        state_d = ST_HALTED;
                    end
                end
                ST_HALTED: begin
                    state_d = ST_HALTED;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            if (push) begin
                fetch_pc_d = fetch_pc_q + 16'd1;
                wr_ptr_d   = wr_ptr_q + PTR_ONE;
            end

            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end

            unique case ({push, pop})
                2'b10:   level_d = level_q + LVL_ONE;
                2'b01:   level_d = level_q - LVL_ONE;
                default: level_d = level_q;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Control registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_VECTOR;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
        end
    end

    // -----------------------------------------------------------------------
    // FIFO entries: one write-enabled register pair per slot
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_q == PW'(gi))) begin
                    entry_byte_q[gi] <= rom_data;
                    entry_addr_q[gi] <= fetch_pc_q;
                end
            end
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // The head is read asynchronously so a byte pushed at one edge is
    // presented in the very next cycle.
    assign instr_byte  = entry_byte_q[rd_ptr_q];
    assign instr_addr  = entry_addr_q[rd_ptr_q];
    assign instr_valid = (level_q != '0);
    assign level       = level_q;
    assign rom_addr    = fetch_pc_q;
    assign halted      = (state_q == ST_HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Bench for fetch_unit. A queue-based reference model tracks the FIFO
// contents, fetch pc and fetch mode. A compare process checks every DUT
// output against the model on each falling clock edge. Directed scenarios
// pin the model with hand-computed literal values, and a randomized phase
// then exercises redirects, halts, back-pressure and asynchronous resets.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    localparam int          DEPTH = 4;
    localparam logic [15:0] RV    = 16'h0000;

    logic        clk;
    logic        rst_n;
    logic        fetch_en;
    logic [15:0] rom_addr;
    logic [7:0]  rom_data;
    logic        redirect;
    logic [15:0] redirect_addr;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  instr_byte;
    logic [15:0] instr_addr;
    logic        halted;
    logic [2:0]  level;

    logic [7:0]  rom_mem [0:65535];

    int n_cmp = 0;
    int n_bad = 0;

    fetch_unit #(
        .DEPTH        (DEPTH),
        .RESET_VECTOR (RV),
        .HALT_OPCODE  (8'hFF)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fetch_en      (fetch_en),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_byte    (instr_byte),
        .instr_addr    (instr_addr),
        .halted        (halted),
        .level         (level)
    );

    assign rom_data = rom_mem[rom_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Reference model: FIFO as a queue of {byte, addr}
    // -----------------------------------------------------------------------
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic [23:0] m_q [$];
    logic [15:0] m_pc   = RV;
    int          m_mode = M_IDLE;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_pc   <= RV;
            m_mode <= M_IDLE;
        end else begin
            automatic int         occ  = m_q.size();
            automatic bit         pop  = (occ != 0) && instr_ready && !redirect;
            automatic bit         push = (m_mode == M_RUN) && fetch_en && !redirect &&
                                         ((occ < DEPTH) || pop);
            automatic logic [7:0] b    = rom_mem[m_pc];
            if (redirect) begin
                m_q.delete();
                m_pc   <= redirect_addr;
                m_mode <= fetch_en ? M_RUN : M_IDLE;
            end else begin
                if (pop) void'(m_q.pop_front());
                if (push) begin
                    m_q.push_back({b, m_pc});
                    m_pc <= m_pc + 16'd1;
                end
                if (m_mode == M_IDLE && fetch_en)       m_mode <= M_RUN;
                else if (m_mode == M_RUN && !fetch_en)  m_mode <= M_IDLE;
                else if (push && b == 8'hFF)            m_mode <= M_HALT;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        check("rom_addr",    32'(rom_addr),    32'(m_pc));
        check("level",       32'(level),       32'(m_q.size()));
        check("instr_valid", 32'(instr_valid), 32'(m_q.size() != 0));
        check("halted",      32'(halted),      32'(m_mode == M_HALT));
        if (m_q.size() != 0) begin
            check("instr_byte", 32'(instr_byte), 32'(m_q[0][23:16]));
            check("instr_addr", 32'(instr_addr), 32'(m_q[0][15:0]));
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus helpers
    // -----------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        fetch_en    = 1'b0;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_addr = 16'h0000;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] exp_b [4];
        exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33; exp_b[3] = 8'h44;

        for (int a = 0; a < 65536; a++) rom_mem[a] = 8'($urandom_range(0, 254));
        for (int a = 0; a < 4; a++) rom_mem[a] = exp_b[a];

        // ---- Reset state and in-order streaming
        do_reset();
        check("rst_level", 32'(level), 0);
        check("rst_valid", 32'(instr_valid), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_rom_addr", 32'(rom_addr), 32'(RV));
        fetch_en = 1'b1; instr_ready = 1'b1;
        step();
        check("s1_valid_before_fetch", 32'(instr_valid), 0);
        for (int k = 0; k < 4; k++) begin
            step();
            check("s1_valid", 32'(instr_valid), 1);
            check("s1_byte", 32'(instr_byte), 32'(exp_b[k]));
            check("s1_addr", 32'(instr_addr), 32'(k));
        end

        // ---- Fill to DEPTH, then push+pop at full
        do_reset();
        fetch_en = 1'b1; instr_ready = 1'b0;
        repeat (7) step();
        check("s2_level_full", 32'(level), 4);
        check("s2_rom_addr_hold", 32'(rom_addr), 32'h0004);
        instr_ready = 1'b1;
        step();
        check("s2_level_pp", 32'(level), 4);
        check("s2_head_addr", 32'(instr_addr), 1);
        check("s2_rom_addr_pp", 32'(rom_addr), 32'h0005);
        step();
        check("s2_level_pp2", 32'(level), 4);
        check("s2_head_addr2", 32'(instr_addr), 2);

        // ---- Redirect flush with address wrap
        do_reset();
        fetch_en = 1'b1; instr_ready = 1'b0;
        repeat (4) step();
        check("s3_level3", 32'(level), 3);
        redirect = 1'b1; redirect_addr = 16'hFFFE;
        step();
        redirect = 1'b0;
        check("s3_flush_level", 32'(level), 0);
        check("s3_rom_addr", 32'(rom_addr), 32'hFFFE);
        instr_ready = 1'b1;
        step();
        check("s3_addr_fffe", 32'(instr_addr), 32'hFFFE);
        step();
        check("s3_addr_ffff", 32'(instr_addr), 32'hFFFF);
        step();
        check("s3_addr_0000", 32'(instr_addr), 32'h0000);
        check("s3_rom_addr_wrap", 32'(rom_addr), 32'h0001);

        // ---- Halt opcode and redirect out of HALTED
        rom_mem[5] = 8'hFF;
        do_reset();
        fetch_en = 1'b1; instr_ready = 1'b1;
        repeat (6) step();
        check("s4_not_halted", 32'(halted), 0);
        step();
        check("s4_halted", 32'(halted), 1);
        check("s4_rom_addr", 32'(rom_addr), 32'h0006);
        check("s4_head_byte", 32'(instr_byte), 32'hFF);
        check("s4_head_addr", 32'(instr_addr), 32'h0005);
        repeat (3) step();
        check("s4_drained", 32'(level), 0);
        check("s4_rom_addr_held", 32'(rom_addr), 32'h0006);
        redirect = 1'b1; redirect_addr = 16'h0010;
        step();
        redirect = 1'b0;
        check("s4_unhalted", 32'(halted), 0);
        check("s4_rom_addr_redir", 32'(rom_addr), 32'h0010);
        step();
        check("s4_resume_addr", 32'(instr_addr), 32'h0010);
        rom_mem[5] = 8'h55;

        // ---- Asynchronous reset without a clock edge
        do_reset();
        fetch_en = 1'b1; instr_ready = 1'b0;
        repeat (3) step();
        check("s5_level2", 32'(level), 2);
        #2 rst_n = 1'b0;
        #1;
        check("s5_async_valid", 32'(instr_valid), 0);
        check("s5_async_rom_addr", 32'(rom_addr), 32'(RV));
        check("s5_async_level", 32'(level), 0);

        // ---- fetch_en drop: consumer drains, no new pushes
        do_reset();
        fetch_en = 1'b1; instr_ready = 1'b0;
        repeat (3) step();
        fetch_en = 1'b0;
        step();
        check("s6_level_hold", 32'(level), 2);
        check("s6_rom_addr", 32'(rom_addr), 32'h0002);
        instr_ready = 1'b1;
        step();
        check("s6_drain1_level", 32'(level), 1);
        check("s6_drain1_addr", 32'(instr_addr), 1);
        step();
        check("s6_drain2_level", 32'(level), 0);
        step();
        check("s6_idle_rom_addr", 32'(rom_addr), 32'h0002);

        // ---- Randomized phase
        for (int a = 0; a < 512; a++)
            rom_mem[a] = ($urandom_range(0, 29) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
        for (int a = 16'hFE00; a < 65536; a++)
            rom_mem[a] = ($urandom_range(0, 29) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            rst_n       = 1'b1;
            fetch_en    = ($urandom_range(0, 9) < 8);
            instr_ready = ($urandom_range(0, 9) < 6);
            redirect    = ($urandom_range(0, 99) < 4);
            redirect_addr = $urandom_range(0, 1) ? 16'($urandom_range(0, 400))
                                                 : 16'(16'hFE00 + $urandom_range(0, 511));
            if ($urandom_range(0, 499) == 0) begin
                #2 rst_n = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
